uart_tx_gen: RTL and testbench

Parametrised UART transmitter. Next generation of the fixed 8-bit tx block, with configurable data width, parity mode, stop-bit count and an internal baud divider. It sits between the host-side data producer (DATA/NEW_DATA handshake) and the serial line TX. It serialises one frame per accepted word, LSB first.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_gen_baud.sv | 29 ++
 rtl/uart_tx_gen.sv | 137 +++++++++++++
 tb/tb_uart_tx_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and the
// parity helper reused by the tx block and its future rx counterpart.
package uart_pkg;

  localparam int unsigned PAR_NONE       = 0;
  localparam int unsigned PAR_EVEN       = 1;
  localparam int unsigned PAR_ODD        = 2;
  localparam int unsigned MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } tx_state_t;

  // XOR of the low 'width' bits; inverted for odd parity.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input int unsigned width,
                                       input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < width) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_gen_baud.sv
// baud_tick_gen: down-counter producing a one-cycle tick every CLKS_PER_BIT
// cycles; restart holds it at the reload value so the first tick lands one full bit later.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_c = !restart && (cnt_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter: start, DATA_WIDTH data bits LSB first, optional
// parity, 1-2 stop bits. Define UART_TX_BREAK_EN to add the BREAK input.
module uart_tx_gen #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  NEW_DATA,
`ifdef UART_TX_BREAK_EN
  input  logic                  BREAK,
`endif
  output logic                  STROBE,
  output logic                  BUSY,
  output logic                  TX
);

  import uart_pkg::*;

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  tx_state_t             state_q, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_nxt;
  logic                  par_q;
  logic                  armed_q, armed_nxt;
  logic                  brk_q, brk_nxt;
  logic                  accept_c, mark_c, tick_c, restart_c, break_req_c;
  logic                  tx_nxt, busy_nxt;

`ifdef UART_TX_BREAK_EN
  assign break_req_c = BREAK;
`else
  assign break_req_c = 1'b0;
`endif

  // Baud counter sits at reload while idle, so every bit starts a fresh count.
  assign restart_c = (state_q == S_IDLE);

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLK    (CLK),
    .RST    (RST),
    .restart(restart_c),
    .tick_c (tick_c)
  );

  // Next state and datapath
  always_comb begin
    state_nxt   = state_q;
    accept_c    = 1'b0;
    mark_c      = 1'b0;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt_q;
    brk_nxt     = (state_q == S_IDLE) && break_req_c;

    case (state_q)
      S_IDLE: begin
        if (!break_req_c) begin
          if (brk_q) begin
            state_nxt = S_STOP;
            mark_c    = 1'b1;
          end else if (NEW_DATA && armed_q) begin
            state_nxt = S_START;
            accept_c  = 1'b1;
          end
        end
      end
      S_START: if (tick_c) state_nxt = S_DATA;
      S_DATA: begin
        if (tick_c && (bit_cnt_q == LAST_DATA)) begin
          state_nxt = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
        end
      end
      S_PAR:  if (tick_c) state_nxt = S_STOP;
      S_STOP: if (tick_c && (bit_cnt_q == LAST_STOP)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (accept_c) begin
      shift_nxt = DATA;
    end else if ((state_q == S_DATA) && tick_c) begin
      shift_nxt = shift_q >> 1;
    end

    // Post-break mark reuses STOP, preloaded so it lasts exactly one bit.
    if (mark_c) begin
      bit_cnt_nxt = LAST_STOP;
    end else if (tick_c) begin
      bit_cnt_nxt = (state_nxt != state_q) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
    end

    armed_nxt = !NEW_DATA ? 1'b1 : (accept_c ? 1'b0 : armed_q);
  end

  // Output values for the cycle after this edge
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      S_PAR:   tx_nxt = par_q;
      default: tx_nxt = 1'b1;
    endcase
    if (brk_nxt) tx_nxt = 1'b0;
    busy_nxt = (state_nxt != S_IDLE) || brk_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      armed_q   <= 1'b1;
      brk_q     <= 1'b0;
      TX        <= 1'b1;
      BUSY      <= 1'b0;
      STROBE    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      shift_q   <= shift_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      armed_q   <= armed_nxt;
      brk_q     <= brk_nxt;
      if (accept_c) par_q <= calc_parity(MAX_DATA_WIDTH'(DATA), DATA_WIDTH, PARITY);
      TX        <= tx_nxt;
      BUSY      <= busy_nxt;
      STROBE    <= accept_c;
    end
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Scoreboard bench for uart_tx_gen: four configurations (8N1, 8E1, 8O1, 5N2) at
// 4 clocks per bit; expected frames are hand-written bit strings in line order.
`timescale 1ns/1ps
module tb_uart_tx_gen;
  import uart_pkg::*;

  localparam int unsigned CPB = 4;
  localparam int unsigned N   = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [7:0]   data0, data1, data2;
  logic [4:0]   data3;
  logic [N-1:0] nd;
  logic [N-1:0] tx, busy, strobe;
`ifdef UART_TX_BREAK_EN
  logic [N-1:0] brk;
`endif

  always #5 CLK = ~CLK;

  typedef struct {
    int    dut;
    string bits;
    bit    full;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  uart_tx_gen #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
    .CLK(CLK), .RST(RST), .DATA(data0), .NEW_DATA(nd[0]),
`ifdef UART_TX_BREAK_EN
    .BREAK(brk[0]),
`endif
    .STROBE(strobe[0]), .BUSY(busy[0]), .TX(tx[0]));

  uart_tx_gen #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_8e1 (
    .CLK(CLK), .RST(RST), .DATA(data1), .NEW_DATA(nd[1]),
`ifdef UART_TX_BREAK_EN
    .BREAK(brk[1]),
`endif
    .STROBE(strobe[1]), .BUSY(busy[1]), .TX(tx[1]));

  uart_tx_gen #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_ODD), .STOP_BITS(1)) u_8o1 (
    .CLK(CLK), .RST(RST), .DATA(data2), .NEW_DATA(nd[2]),
`ifdef UART_TX_BREAK_EN
    .BREAK(brk[2]),
`endif
    .STROBE(strobe[2]), .BUSY(busy[2]), .TX(tx[2]));

  uart_tx_gen #(.DATA_WIDTH(5), .CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(2)) u_5n2 (
    .CLK(CLK), .RST(RST), .DATA(data3), .NEW_DATA(nd[3]),
`ifdef UART_TX_BREAK_EN
    .BREAK(brk[3]),
`endif
    .STROBE(strobe[3]), .BUSY(busy[3]), .TX(tx[3]));

  // Monitor: each STROBE pops one expected frame and follows it bit by bit.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (strobe !== '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(strobe), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("strobe_dut", 32'(strobe), 32'(1) << e.dut);
          for (int b = 0; b < e.bits.len(); b++) begin
            for (int c = 0; c < int'(CPB); c++) begin
              if (b != 0 || c != 0) @(negedge CLK);
              check($sformatf("dut%0d_tx_bit%0d", e.dut, b), 32'(tx[e.dut]),
                    32'(e.bits[b] == "1"));
              check($sformatf("dut%0d_busy_bit%0d", e.dut, b), 32'(busy[e.dut]), 32'(1));
              check($sformatf("dut%0d_strobe_bit%0d", e.dut, b), 32'(strobe[e.dut]),
                    32'(b == 0 && c == 0));
            end
          end
          if (e.full) begin
            @(negedge CLK);
            check($sformatf("dut%0d_busy_fall", e.dut), 32'(busy[e.dut]), 32'(0));
            check($sformatf("dut%0d_idle_tx", e.dut), 32'(tx[e.dut]), 32'(1));
          end
        end
      end
    end
  end

  task automatic wait_idle(input int d, input int limit, input string name);
    int n = 0;
    while (busy[d] !== 1'b0 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check(name, 32'(busy[d]), 32'(0));
  endtask

  task automatic wait_strobe(input int d, input int limit, input string name);
    int n = 0;
    while (strobe[d] !== 1'b1 && n < limit) begin
      @(negedge CLK);
      n++;
    end
    check(name, 32'(strobe[d]), 32'(1));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int mark;
    int n;
    RST = 1'b1;
    nd  = '0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
`ifdef UART_TX_BREAK_EN
    brk = '0;
`endif
    repeat (3) @(negedge CLK);
    check("reset_tx", 32'(tx), 32'(4'hF));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_strobe", 32'(strobe), 32'(0));
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_tx", 32'(tx), 32'(4'hF));

    // 8N1 0x53 with NEW_DATA held 10 cycles: exactly one frame
    exp_q.push_back('{dut: 0, bits: "0110010101", full: 1'b1});
    data0 = 8'h53; nd[0] = 1'b1;
    repeat (10) @(negedge CLK);
    nd[0] = 1'b0;
    wait_idle(0, 60, "t1_done");
    repeat (10) @(negedge CLK);

    // Even and odd parity on 0x53
    exp_q.push_back('{dut: 1, bits: "01100101001", full: 1'b1});
    data1 = 8'h53; nd[1] = 1'b1;
    @(negedge CLK); nd[1] = 1'b0;
    wait_idle(1, 60, "t2_even_done");
    repeat (3) @(negedge CLK);
    exp_q.push_back('{dut: 2, bits: "01100101011", full: 1'b1});
    data2 = 8'h53; nd[2] = 1'b1;
    @(negedge CLK); nd[2] = 1'b0;
    wait_idle(2, 60, "t2_odd_done");
    repeat (3) @(negedge CLK);

    // 5 data bits, 2 stop bits
    exp_q.push_back('{dut: 3, bits: "01010111", full: 1'b1});
    data3 = 5'h15; nd[3] = 1'b1;
    @(negedge CLK); nd[3] = 1'b0;
    wait_idle(3, 60, "t3_done");
    repeat (3) @(negedge CLK);

    // Mid-frame request ignored, then back-to-back with one idle cycle
    exp_q.push_back('{dut: 0, bits: "0001111001", full: 1'b1});
    data0 = 8'h3C; nd[0] = 1'b1;
    @(negedge CLK); nd[0] = 1'b0;
    repeat (12) @(negedge CLK);
    data0 = 8'hAA; nd[0] = 1'b1;
    @(negedge CLK); nd[0] = 1'b0;
    exp_q.push_back('{dut: 0, bits: "0010101011", full: 1'b1});
    repeat (20) @(negedge CLK);
    nd[0] = 1'b1;
    wait_idle(0, 30, "t4_first_done");
    @(negedge CLK);
    check("t4_min_gap_strobe", 32'(strobe[0]), 32'(1));
    nd[0] = 1'b0;
    wait_idle(0, 60, "t4_second_done");
    repeat (3) @(negedge CLK);

    // Asynchronous reset during the third data bit, restart with NEW_DATA held
    exp_q.push_back('{dut: 0, bits: "011", full: 1'b0});
    data0 = 8'h53; nd[0] = 1'b1;
    @(negedge CLK);
    repeat (13) @(negedge CLK);
    check("t5_pre_reset_busy", 32'(busy[0]), 32'(1));
    #2 RST = 1'b1;
    #1;
    check("t5_async_tx", 32'(tx[0]), 32'(1));
    check("t5_async_busy", 32'(busy[0]), 32'(0));
    exp_q.push_back('{dut: 0, bits: "0110010101", full: 1'b1});
    @(negedge CLK);
    RST = 1'b0;
    wait_strobe(0, 10, "t5_restart");
    nd[0] = 1'b0;
    wait_idle(0, 60, "t5_done");
    repeat (3) @(negedge CLK);

`ifdef UART_TX_BREAK_EN
    // Break while idle, then one-bit mark before the next acceptance
    brk[0] = 1'b1; nd[0] = 1'b1; data0 = 8'h53;
    repeat (20) begin
      @(negedge CLK);
      check("t6_break_tx", 32'(tx[0]), 32'(0));
      check("t6_break_busy", 32'(busy[0]), 32'(1));
    end
    exp_q.push_back('{dut: 0, bits: "0110010101", full: 1'b1});
    brk[0] = 1'b0;
    mark = 0;
    n = 0;
    while (n < 20) begin
      @(negedge CLK);
      n++;
      if (strobe[0] === 1'b1) break;
      if (tx[0] === 1'b1) mark++;
    end
    check("t6_resume_strobe", 32'(strobe[0]), 32'(1));
    check("t6_mark_len_ok", 32'(mark >= int'(CPB) && mark <= int'(CPB) + 1), 32'(1));
    nd[0] = 1'b0;
    wait_idle(0, 60, "t6_done");
    repeat (3) @(negedge CLK);
`endif

    repeat (10) @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
